// File: rtl/latch_wr_sequencer_if.sv
// Request/latch-bus bundle for latch_wr_sequencer.
//
// Parameters:
//   WIDTH - latch data width
//   NREGS - number of latches in the bank; AW = $clog2(NREGS)
//
// Signals:
//   req0/req1   write request from requester 0/1
//   addr0/addr1 target latch index
//   data0/data1 write data
//   ack0/ack1   one-cycle completion pulse back to requester 0/1
//   lat_d       shared data bus to the latch D inputs
//   lat_en      one-hot latch enables
//   busy        sequencer is not idle
//
// Modports:
//   master - requester/bench side: drives requests, observes acks and the latch bus
//   slave  - sequencer side
interface latch_wr_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4
);
  localparam int unsigned AW = $clog2(NREGS);

  logic             req0;
  logic             req1;
  logic [AW-1:0]    addr0;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] lat_d;
  logic [NREGS-1:0] lat_en;
  logic             busy;

  modport master (
    output req0, req1, addr0, addr1, data0, data1,
    input  ack0, ack1, lat_d, lat_en, busy
  );

  modport slave (
    input  req0, req1, addr0, addr1, data0, data1,
    output ack0, ack1, lat_d, lat_en, busy
  );
endinterface

// File: rtl/latch_wr_sequencer.sv
// Write sequencer and two-port arbiter for a bank of level-sensitive D latches that share
// one data bus and have one enable each. A granted write runs SETUP -> PULSE -> HOLD so the
// latch data is stable around every enable window and enables never overlap.
//
// Parameters:
//   WIDTH     - latch data width
//   NREGS     - number of latches (power of two, >= 2)
//   SETUP_CYC - cycles data is driven before the enable rises (>= 1)
//   PULSE_CYC - cycles the enable is high (>= 1)
//   HOLD_CYC  - cycles data is held after the enable falls (>= 1)
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - latch_wr_sequencer_if.slave: requests in, acks/latch bus/busy out
//
// Build option:
//   LATCH_WR_FIXED_PRIO_EN - when defined, requester 0 always wins simultaneous requests and
//   the round-robin pointer is removed; requester 1 can starve. Default: round-robin.
//
// Grant edge G is an IDLE cycle with an effective request. SETUP then covers G+1..G+SETUP_CYC,
// PULSE and HOLD follow, and the ack pulse appears in the IDLE cycle after the last HOLD cycle
// (latency SETUP_CYC+PULSE_CYC+HOLD_CYC+1).
module latch_wr_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NREGS     = 4,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input logic                 clk,
  input logic                 reset,
  latch_wr_sequencer_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);

  // The phase counter only has to hold the largest reload value (phase length - 1).
  localparam int unsigned MaxCyc =
      (SETUP_CYC > PULSE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                              : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int unsigned CW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CW-1:0] SetupLoad = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PulseLoad = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HoldLoad  = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    sel_q, sel_d;
  logic             own_q, own_d;       // requester that owns the in-flight write
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic [NREGS-1:0] lat_en_q, lat_en_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;

  logic r0, r1;
  logic gnt_valid;
  logic gnt_id;
  logic grant;
  logic phase_done;

  // ---------------------------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------------------------
`ifdef LATCH_WR_FIXED_PRIO_EN
  // Requests are taken as-is: a requester 0 that keeps req high through its ack is granted
  // again straight away, which is what lets it lock requester 1 out.
  assign r0     = bus.req0;
  assign r1     = bus.req1;
  assign gnt_id = ~r0;
`else
  logic last_q, last_d;

  // A requester is masked in its own ack cycle so a req still high there is not re-granted;
  // the other requester is visible and can win on that edge.
  assign r0     = bus.req0 & ~ack0_q;
  assign r1     = bus.req1 & ~ack1_q;
  // Requester 1 wins when alone, or when both ask and requester 0 was served last.
  assign gnt_id = r1 & (~r0 | ~last_q);
`endif

  assign gnt_valid  = r0 | r1;
  assign grant      = (state_q == StIdle) & gnt_valid;
  assign phase_done = (cnt_q == '0);

  // ---------------------------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sel_q    <= '0;
      own_q    <= 1'b0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
`ifndef LATCH_WR_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      own_q    <= own_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
`ifndef LATCH_WR_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          state_d = StSetup;
          cnt_d   = SetupLoad;
        end
      end
      StSetup: begin
        if (phase_done) begin
          state_d = StPulse;
          cnt_d   = PulseLoad;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StPulse: begin
        if (phase_done) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StHold: begin
        if (phase_done) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Output logic (all outputs are registered next cycle)
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    sel_d    = sel_q;
    own_d    = own_q;
    lat_d_d  = lat_d_q;
    lat_en_d = '0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
`ifndef LATCH_WR_FIXED_PRIO_EN
    last_d   = last_q;
`endif

    // Request inputs are sampled only here; later changes cannot reach the latch bus.
    if (grant) begin
      sel_d   = gnt_id ? bus.addr1 : bus.addr0;
      lat_d_d = gnt_id ? bus.data1 : bus.data0;
      own_d   = gnt_id;
`ifndef LATCH_WR_FIXED_PRIO_EN
      last_d  = gnt_id;
`endif
    end

    // Enable register is loaded from the next state, so it is high exactly in PULSE cycles.
    if (state_d == StPulse) begin
      lat_en_d[sel_q] = 1'b1;
    end

    if ((state_q == StHold) && phase_done) begin
      ack0_d = ~own_q;
      ack1_d = own_q;
    end
  end

  assign bus.lat_d  = lat_d_q;
  assign bus.lat_en = lat_en_q;
  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.busy   = (state_q != StIdle);

  // ---------------------------------------------------------------------------------------------
  // Safety properties
  // ---------------------------------------------------------------------------------------------
  a_en_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(lat_en_q));

  a_en_only_in_pulse: assert property (@(posedge clk) disable iff (reset)
      (lat_en_q != '0) |-> (state_q == StPulse));

  a_ack_exclusive: assert property (@(posedge clk) disable iff (reset) !(ack0_q && ack1_q));

  a_ack_in_idle: assert property (@(posedge clk) disable iff (reset)
      (ack0_q || ack1_q) |-> (state_q == StIdle));

endmodule

// File: tb/tb_latch_wr_sequencer.sv
// Self-checking bench for latch_wr_sequencer. DUT A uses default timing, DUT B uses
// SETUP/PULSE/HOLD = 2/3/2. Expected writes for DUT A go into a scoreboard queue when they are
// driven and are popped by a monitor on every ack, which also models the latch bank.
module tb_latch_wr_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREGS = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned SA = 1, PA = 2, HA = 1;
  localparam int unsigned SB = 2, PB = 3, HB = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  latch_wr_sequencer_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus_a ();
  latch_wr_sequencer_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus_b ();

  latch_wr_sequencer #(
    .WIDTH(WIDTH), .NREGS(NREGS), .SETUP_CYC(SA), .PULSE_CYC(PA), .HOLD_CYC(HA)
  ) u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  latch_wr_sequencer #(
    .WIDTH(WIDTH), .NREGS(NREGS), .SETUP_CYC(SB), .PULSE_CYC(PB), .HOLD_CYC(HB)
  ) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  typedef struct packed {
    logic             id;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  wr_t         sb_q[$];
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] idx_of(input logic [NREGS-1:0] en);
    idx_of = '0;
    for (int i = 0; i < NREGS; i++) if (en[i]) idx_of = AW'(i);
  endfunction

  // -----------------------------------------------------------------------------------------------
  // Monitor for DUT A: latch model, enable-window rules, scoreboard pop on ack
  // -----------------------------------------------------------------------------------------------
  logic             rst_edge = 1'b1;  // last rising edge was a reset edge
  logic [NREGS-1:0] prev_en  = '0;
  int unsigned      win_len  = 0;
  logic [AW-1:0]    win_idx  = '0;
  logic [WIDTH-1:0] win_data = '0;
  logic [WIDTH-1:0] latch_mem[NREGS];
  wr_t              mon_e;

  always @(posedge clk) rst_edge <= reset;

  always @(negedge clk) begin
    if (rst_edge) begin
      prev_en = '0;
      win_len = 0;
    end else begin
      if (bus_a.lat_en != '0) begin
        check_eq("en_onehot", $countones(bus_a.lat_en), 1);
        if (prev_en == '0) begin
          win_len  = 1;
          win_idx  = idx_of(bus_a.lat_en);
          win_data = bus_a.lat_d;
        end else begin
          check_eq("en_adjacent", bus_a.lat_en, prev_en);
          check_eq("d_stable_in_pulse", bus_a.lat_d, win_data);
          win_len++;
        end
        latch_mem[win_idx] = bus_a.lat_d;  // transparent latch
      end else if (prev_en != '0) begin
        check_eq("pulse_len", win_len, PA);
      end
      prev_en = bus_a.lat_en;

      if (bus_a.ack0 || bus_a.ack1) begin
        check_eq("ack_exclusive", bus_a.ack0 & bus_a.ack1, 0);
        if (sb_q.size() == 0) begin
          check_eq("unexpected_ack", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("ack_id", bus_a.ack1, mon_e.id);
          check_eq("win_addr", win_idx, mon_e.addr);
          check_eq("latch_data", latch_mem[mon_e.addr], mon_e.data);
        end
      end
    end
  end

  // -----------------------------------------------------------------------------------------------
  // Stimulus helpers
  // -----------------------------------------------------------------------------------------------
  // One requester-0 write with a cycle-by-cycle timing check against s/p/h.
  task automatic directed(input bit use_b, input int unsigned s, input int unsigned p,
                          input int unsigned h, input logic [AW-1:0] addr,
                          input logic [WIDTH-1:0] data, input string tag);
    logic [NREGS-1:0] en, exp_en;
    logic             ack, busy;
    logic [WIDTH-1:0] d;
    wr_t              e;
    @(negedge clk);
    if (use_b) begin
      bus_b.req0 = 1'b1; bus_b.addr0 = addr; bus_b.data0 = data;
    end else begin
      bus_a.req0 = 1'b1; bus_a.addr0 = addr; bus_a.data0 = data;
      e.id = 1'b0; e.addr = addr; e.data = data;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= int'(s + p + h + 2); k++) begin
      @(negedge clk);
      if (use_b) begin
        en = bus_b.lat_en; ack = bus_b.ack0; busy = bus_b.busy; d = bus_b.lat_d;
      end else begin
        en = bus_a.lat_en; ack = bus_a.ack0; busy = bus_a.busy; d = bus_a.lat_d;
      end
      exp_en = (k > int'(s) && k <= int'(s + p)) ? (NREGS'(1) << addr) : '0;
      check_eq($sformatf("%s_en_g%0d", tag, k), en, exp_en);
      check_eq($sformatf("%s_ack_g%0d", tag, k), ack, (k == int'(s + p + h + 1)));
      check_eq($sformatf("%s_busy_g%0d", tag, k), busy, (k <= int'(s + p + h)));
      if (k <= int'(s + p + h)) check_eq($sformatf("%s_d_g%0d", tag, k), d, data);
      if (ack) begin
        if (use_b) bus_b.req0 = 1'b0;
        else bus_a.req0 = 1'b0;
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // -----------------------------------------------------------------------------------------------
  // Main sequence
  // -----------------------------------------------------------------------------------------------
  int unsigned cnt0, cnt1;
  bit          seen;
  wr_t         e;

  initial begin
    for (int i = 0; i < NREGS; i++) latch_mem[i] = '0;
    bus_a.req0 = 0; bus_a.req1 = 0; bus_a.addr0 = '0; bus_a.addr1 = '0;
    bus_a.data0 = '0; bus_a.data1 = '0;
    bus_b.req0 = 0; bus_b.req1 = 0; bus_b.addr0 = '0; bus_b.addr1 = '0;
    bus_b.data0 = '0; bus_b.data1 = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check_eq("rst_lat_d", bus_a.lat_d, 0);
    check_eq("rst_lat_en", bus_a.lat_en, 0);
    check_eq("rst_ack", {bus_a.ack0, bus_a.ack1}, 0);
    check_eq("rst_busy", bus_a.busy, 0);
    reset = 1'b0;

    // Single write, default timing
    directed(1'b0, SA, PA, HA, 2'd2, 8'hA5, "single");

    // Simultaneous requests from a fresh reset
    reset_pulse();
    cnt0 = 0; cnt1 = 0;
`ifdef LATCH_WR_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) begin
      e.id = 1'b0; e.addr = 2'd0; e.data = 8'h11; sb_q.push_back(e);
    end
    bus_a.req0 = 1; bus_a.addr0 = 2'd0; bus_a.data0 = 8'h11;
    bus_a.req1 = 1; bus_a.addr1 = 2'd1; bus_a.data1 = 8'h22;
    for (int c = 0; c < 80 && cnt0 < 3; c++) begin
      @(negedge clk);
      if (bus_a.ack1) check_eq("fixed_ack1", 1, 0);
      if (bus_a.ack0) begin
        cnt0++;
        if (cnt0 == 3) begin
          bus_a.req0 = 0; bus_a.req1 = 0;
        end
      end
    end
    check_eq("fixed_acks0", cnt0, 3);
`else
    e.id = 1'b0; e.addr = 2'd0; e.data = 8'h11; sb_q.push_back(e);
    e.id = 1'b1; e.addr = 2'd1; e.data = 8'h22; sb_q.push_back(e);
    e.id = 1'b0; e.addr = 2'd0; e.data = 8'h13; sb_q.push_back(e);
    e.id = 1'b1; e.addr = 2'd1; e.data = 8'h24; sb_q.push_back(e);
    bus_a.req0 = 1; bus_a.addr0 = 2'd0; bus_a.data0 = 8'h11;
    bus_a.req1 = 1; bus_a.addr1 = 2'd1; bus_a.data1 = 8'h22;
    for (int c = 0; c < 80 && !(cnt0 == 2 && cnt1 == 2); c++) begin
      @(negedge clk);
      if (bus_a.ack0) begin
        cnt0++;
        if (cnt0 == 2) bus_a.req0 = 0;
        else bus_a.data0 = 8'h13;
      end
      if (bus_a.ack1) begin
        cnt1++;
        if (cnt1 == 2) bus_a.req1 = 0;
        else bus_a.data1 = 8'h24;
      end
    end
    check_eq("rr_acks0", cnt0, 2);
    check_eq("rr_acks1", cnt1, 2);
`endif
    repeat (2) @(negedge clk);

    // Reset during PULSE abandons the write
    bus_a.req0 = 1; bus_a.addr0 = 2'd3; bus_a.data0 = 8'h5A;
    repeat (2) @(negedge clk);  // G+2
    check_eq("abort_in_pulse", bus_a.lat_en, 4'b1000);
    reset = 1'b1;
    bus_a.req0 = 0;
    @(negedge clk);
    check_eq("abort_lat_en", bus_a.lat_en, 0);
    check_eq("abort_busy", bus_a.busy, 0);
    check_eq("abort_ack", {bus_a.ack0, bus_a.ack1}, 0);
    check_eq("abort_lat_d", bus_a.lat_d, 0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("abort_no_ack", bus_a.ack0 | bus_a.ack1, 0);
    end

    // Requester 1 granted normally after the abort
    e.id = 1'b1; e.addr = 2'd2; e.data = 8'h77; sb_q.push_back(e);
    bus_a.req1 = 1; bus_a.addr1 = 2'd2; bus_a.data1 = 8'h77;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus_a.ack1) begin
        seen = 1;
        bus_a.req1 = 0;
        check_eq("req1_latency", c + 1, SA + PA + HA + 1);
      end
    end
    check_eq("req1_ack_seen", seen, 1);
    @(negedge clk);

    // Input change after the grant is ignored
    e.id = 1'b0; e.addr = 2'd1; e.data = 8'h3C; sb_q.push_back(e);
    bus_a.req0 = 1; bus_a.addr0 = 2'd1; bus_a.data0 = 8'h3C;
    for (int k = 1; k <= int'(SA + PA + HA); k++) begin
      @(negedge clk);
      check_eq($sformatf("chg_lat_d_g%0d", k), bus_a.lat_d, 8'h3C);
      if (k == 2) bus_a.data0 = 8'hFF;
    end
    @(negedge clk);
    check_eq("chg_ack0", bus_a.ack0, 1);
    bus_a.req0 = 0;
    @(negedge clk);

    // Parameter sweep instance 2/3/2
    directed(1'b1, SB, PB, HB, 2'd3, 8'hC3, "sweep");

    repeat (3) @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard stop in case a wait above never returns
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
